pong_ball_engine: RTL and testbench
===================================

# pong_ball_engine

Parametrised next-generation Pong ball controller. Moves the ball once per `frame_clk` and sequences the rally through idle, serve, play and game-over states. Direction-gated wall and paddle collisions replace per-edge debounce counters, and ball speed ramps up with paddle hits. Sits between the paddle controllers/keyboard decoder and the color mapper/score display.

## Interface
Parameters:
- `X_MIN` = 33, `X_MAX` = 596: goal lines (left/right playfield limits).
- `Y_MIN` = 20, `Y_MAX` = 461: top/bottom wall limits.
- `X_CENTER` = 320, `Y_CENTER` = 240: serve position.
- `BALL_SIZE` = 5: ball half-size.
- `X_STEP_INIT` = 4: serve horizontal speed.
- `X_STEP_MAX` = 12: horizontal speed cap.
- `Y_STEP_MAX` = 7: vertical speed cap, applied after deflection.
- `HITS_PER_SPEEDUP` = 4: paddle hits per +1 speed.
- `SERVE_FRAMES` = 60: frames the ball is held before launch.
- `WIN_SCORE` = 7: points that end a game.
- `SCORE_W` = 4: score width.
- `DEFLECT_SHIFT` = 3: arithmetic shift for paddle deflection.

Ports:
- `frame_clk` in 1: frame clock, one tick per video frame.
- `Reset` in 1: asynchronous, active-high.
- `start` in 1: leave IDLE/OVER.
- `paddle1_x`, `paddle1_y`, `paddle1_l`, `paddle1_w` in 10 each: left paddle centre, half-length, half-width.
- `paddle2_x`, `paddle2_y`, `paddle2_l`, `paddle2_w` in 10 each: right paddle, same fields.
- `ball_x`, `ball_y` out 10: ball centre.
- `ball_s` out 10: constant `BALL_SIZE`.
- `score_l`, `score_r` out SCORE_W: left and right scores.
- `state` out 2: IDLE=0, SERVE=1, PLAY=2, OVER=3.
- `winner` out 2: 00 none, 01 left, 10 right.
- `paddle1_hit`, `paddle2_hit`, `point_l`, `point_r` out 1: one-frame pulses.

## Operation
- **Reset values:** state IDLE; ball at (`X_CENTER`, `Y_CENTER`); `vx` = `vy` = 0; speed = `X_STEP_INIT`; hit count 0; scores 0; winner 00; all pulses 0; serve direction +x.
- **IDLE:** ball held at centre. `start` moves to SERVE with the serve counter cleared.
- **SERVE:** ball held at centre, `vx` = `vy` = 0. Counter runs `SERVE_FRAMES` frames, then PLAY with `vx` = ±`X_STEP_INIT` (serve direction), `vy` = 0, speed and hit count reset.
- **PLAY:** each frame, first matching rule wins, evaluated on current position and velocity.
  1. **Left paddle hit.** Condition: `vx` < 0 and the ball box overlaps the paddle1 box (inclusive compares). Response: `vx` = +speed, `vy` = clamp((`ball_y` − `paddle1_y`) >>> `DEFLECT_SHIFT`, ±`Y_STEP_MAX`), `paddle1_hit` pulse, hit count +1.
  2. **Right paddle hit.** Same as rule 1 with `vx` > 0 and paddle2; `vx` = −speed.
  3. **Left goal.** Condition: `vx` < 0 and `ball_x` − `BALL_SIZE` ≤ `X_MIN`. Response: `score_r` +1, `point_r` pulse, serve direction −x.
  4. **Right goal.** Condition: `vx` > 0 and `ball_x` + `BALL_SIZE` ≥ `X_MAX`. Response: `score_l` +1, `point_l` pulse, serve direction +x. After rule 3 or 4, go to SERVE, or to OVER if the new score equals `WIN_SCORE`, and recentre the ball on the same edge.
  5. **Walls.** `vy` > 0 and `ball_y` + `BALL_SIZE` ≥ `Y_MAX`, or `vy` < 0 and `ball_y` − `BALL_SIZE` ≤ `Y_MIN`: `vy` = −`vy`.
  - If none of rules 1–4 fired, position advances by the velocity held at the start of the frame: `ball_x` += `vx`, `ball_y` += `vy`.
- **Speed ramp:** when the hit count reaches `HITS_PER_SPEEDUP`, the count clears and speed = min(speed + 1, `X_STEP_MAX`). The new speed applies from the next paddle hit.
- **OVER:** ball held at centre; `winner` set. `start` clears scores and winner and goes to SERVE, keeping the serve direction.
- **Arithmetic:** positions are unsigned 10-bit; velocities are signed 11-bit. Deflection is computed in signed 11-bit. Position add uses sign extension, truncated to 10 bits.

## Timing
- All outputs are registered on the `frame_clk` rising edge. Pulses are high for exactly one frame after the detecting edge.
- Score, state and recentre become visible together, on the edge following detection.
- SERVE lasts exactly `SERVE_FRAMES` frames. The ball first moves on the second frame of PLAY.
- **Simultaneous events:** paddle beats goal; goal beats wall. Both paddle hits in one frame cannot occur (vx sign gating). Wall is ignored on a paddle-hit frame (deflection overrides `vy`).
- `start` is ignored in SERVE and PLAY.
- `Reset` at any time, including mid-SERVE or mid-PLAY, forces the reset values immediately.

## Structure
- Shared package `pong_pkg`:
  - `ball_state_t` enum (IDLE/SERVE/PLAY/OVER, 2-bit).
  - `coord_t` (logic[9:0]) and `vel_t` (logic signed[10:0]).
  - `winner_t` encoding constants.
- One combinational sub-module, `pong_box_overlap`: two centre/half-extent boxes in, overlap flag out. Instantiated once per paddle.

## Test plan
- **Reset and serve:** Reset → ball (320,240), state 0, scores 0. `start` pulse → state 1; after 60 frames → state 2, `vx` = +4; next frame `ball_x` = 324.
- **Bottom wall:** `vy` = +3, `ball_y` = 456 → `vy` = −3 next frame. With `vy` negative, no re-flip while `ball_y` + 5 ≥ 461.
- **Paddle2 deflection:** paddle2 (580,240) L = 30, W = 4; ball `vx` = +4, `ball_y` = 256, box overlapping → `paddle2_hit` pulse, `vx` = −4, `vy` = +2.
- **Speed ramp:** 4 alternating paddle hits → speed 5. 36 hits → speed saturates at 12.
- **Right goal:** `ball_x` = 592, `vx` = +4, no paddle overlap → `score_l` = 1, `point_l` pulse, state 1, ball (320,240); after serve, `vx` = +4.
- **Game over and reset:** `score_l` = 6 plus a right goal → `score_l` = 7, state 3, `winner` = 01. `start` → scores 0, state 1. Reset asserted mid-PLAY → state 0, ball at centre.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong ball engine.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } ball_state_t;

  typedef logic [9:0]        coord_t;
  typedef logic signed [10:0] vel_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // Symmetric saturation of a signed velocity to +/-lim.
  function automatic vel_t clamp_vel(input vel_t v, input vel_t lim);
    vel_t r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_box_overlap.sv
// Inclusive overlap test of two centre/half-extent boxes.
module pong_box_overlap
  import pong_pkg::*;
(
  input  coord_t a_x,
  input  coord_t a_y,
  input  coord_t a_hx,
  input  coord_t a_hy,
  input  coord_t b_x,
  input  coord_t b_y,
  input  coord_t b_hx,
  input  coord_t b_hy,
  output logic   overlap
);

  logic [11:0] span_x_s;
  logic [11:0] span_y_s;
  logic        x_ok_s;
  logic        y_ok_s;

  // Widened compares so centre +/- extent never wraps.
  always_comb begin
    span_x_s = {2'b00, a_hx} + {2'b00, b_hx};
    span_y_s = {2'b00, a_hy} + {2'b00, b_hy};
    x_ok_s   = (({2'b00, a_x} + span_x_s) >= {2'b00, b_x}) &&
               (({2'b00, b_x} + span_x_s) >= {2'b00, a_x});
    y_ok_s   = (({2'b00, a_y} + span_y_s) >= {2'b00, b_y}) &&
               (({2'b00, b_y} + span_y_s) >= {2'b00, a_y});
    overlap  = x_ok_s && y_ok_s;
  end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball controller: rally sequencing, motion, collisions, scoring.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int X_MIN            = 33,
  parameter int X_MAX            = 596,
  parameter int Y_MIN            = 20,
  parameter int Y_MAX            = 461,
  parameter int X_CENTER         = 320,
  parameter int Y_CENTER         = 240,
  parameter int BALL_SIZE        = 5,
  parameter int X_STEP_INIT      = 4,
  parameter int X_STEP_MAX       = 12,
  parameter int Y_STEP_MAX       = 7,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SERVE_FRAMES     = 60,
  parameter int WIN_SCORE        = 7,
  parameter int SCORE_W          = 4,
  parameter int DEFLECT_SHIFT    = 3
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [9:0]         paddle1_x,
  input  logic [9:0]         paddle1_y,
  input  logic [9:0]         paddle1_l,
  input  logic [9:0]         paddle1_w,
  input  logic [9:0]         paddle2_x,
  input  logic [9:0]         paddle2_y,
  input  logic [9:0]         paddle2_l,
  input  logic [9:0]         paddle2_w,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic [9:0]         ball_s,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state,
  output logic [1:0]         winner,
  output logic               paddle1_hit,
  output logic               paddle2_hit,
  output logic               point_l,
  output logic               point_r
);

  localparam int HIT_W = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int SC_W  = $clog2(SERVE_FRAMES + 1);

  localparam coord_t X_CENTER_C = coord_t'(X_CENTER);
  localparam coord_t Y_CENTER_C = coord_t'(Y_CENTER);
  localparam coord_t BALL_C     = coord_t'(BALL_SIZE);

  localparam logic [10:0] BS_11      = 11'(BALL_SIZE);
  localparam logic [10:0] GOAL_L_LIM = 11'(X_MIN + BALL_SIZE);
  localparam logic [10:0] GOAL_R_LIM = 11'(X_MAX);
  localparam logic [10:0] WALL_T_LIM = 11'(Y_MIN + BALL_SIZE);
  localparam logic [10:0] WALL_B_LIM = 11'(Y_MAX);

  localparam vel_t STEP_INIT_V = vel_t'(X_STEP_INIT);
  localparam vel_t STEP_MAX_V  = vel_t'(X_STEP_MAX);
  localparam vel_t Y_LIM_V     = vel_t'(Y_STEP_MAX);

  localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HITS_PER_SPEEDUP - 1);
  localparam logic [SC_W-1:0]    SERVE_LAST = SC_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);

  // Registered state
  ball_state_t        state_r,     state_n;
  coord_t             ball_x_r,    ball_x_n;
  coord_t             ball_y_r,    ball_y_n;
  vel_t               vx_r,        vx_n;
  vel_t               vy_r,        vy_n;
  vel_t               speed_r,     speed_n;
  logic [HIT_W-1:0]   hit_cnt_r,   hit_cnt_n;
  logic [SC_W-1:0]    serve_cnt_r, serve_cnt_n;
  logic [SCORE_W-1:0] score_l_r,   score_l_n;
  logic [SCORE_W-1:0] score_r_r,   score_r_n;
  logic [1:0]         winner_r,    winner_n;
  logic               serve_dir_r, serve_dir_n;  // 1 = serve toward +x
  logic               p1_hit_r,    p1_hit_n;
  logic               p2_hit_r,    p2_hit_n;
  logic               point_l_r,   point_l_n;
  logic               point_r_r,   point_r_n;

  // Combinational helpers
  logic               ov1_s, ov2_s;
  logic               hit1_s, hit2_s, goal_l_s, goal_r_s, wall_s;
  logic [10:0]        bx_ext_s, by_ext_s, sum_x_s, sum_y_s;
  vel_t               dy1_s, dy2_s, defl1_s, defl2_s;
  vel_t               speed_up_s;
  logic [HIT_W-1:0]   hit_cnt_up_s;
  logic [SCORE_W-1:0] score_l_inc_s, score_r_inc_s;

  pong_box_overlap u_ov1 (
    .a_x (ball_x_r),  .a_y (ball_y_r),  .a_hx(BALL_C),    .a_hy(BALL_C),
    .b_x (paddle1_x), .b_y (paddle1_y), .b_hx(paddle1_w), .b_hy(paddle1_l),
    .overlap(ov1_s)
  );

  pong_box_overlap u_ov2 (
    .a_x (ball_x_r),  .a_y (ball_y_r),  .a_hx(BALL_C),    .a_hy(BALL_C),
    .b_x (paddle2_x), .b_y (paddle2_y), .b_hx(paddle2_w), .b_hy(paddle2_l),
    .overlap(ov2_s)
  );

  // Collision conditions, deflections, speed ramp and position sums.
  always_comb begin
    bx_ext_s = {1'b0, ball_x_r};
    by_ext_s = {1'b0, ball_y_r};
    hit1_s   = (vx_r < 11'sd0) && ov1_s;
    hit2_s   = (vx_r > 11'sd0) && ov2_s;
    goal_l_s = (vx_r < 11'sd0) && (bx_ext_s <= GOAL_L_LIM);
    goal_r_s = (vx_r > 11'sd0) && ((bx_ext_s + BS_11) >= GOAL_R_LIM);
    wall_s   = ((vy_r > 11'sd0) && ((by_ext_s + BS_11) >= WALL_B_LIM)) ||
               ((vy_r < 11'sd0) && (by_ext_s <= WALL_T_LIM));
    dy1_s    = $signed(by_ext_s) - $signed({1'b0, paddle1_y});
    dy2_s    = $signed(by_ext_s) - $signed({1'b0, paddle2_y});
    defl1_s  = clamp_vel(dy1_s >>> DEFLECT_SHIFT, Y_LIM_V);
    defl2_s  = clamp_vel(dy2_s >>> DEFLECT_SHIFT, Y_LIM_V);
    sum_x_s  = bx_ext_s + vx_r;
    sum_y_s  = by_ext_s + vy_r;
    speed_up_s    = (speed_r >= STEP_MAX_V) ? STEP_MAX_V : (speed_r + 11'sd1);
    hit_cnt_up_s  = hit_cnt_r + {{(HIT_W-1){1'b0}}, 1'b1};
    score_l_inc_s = score_l_r + SCORE_ONE;
    score_r_inc_s = score_r_r + SCORE_ONE;
  end

  // Next-state and next-output logic for the rally sequencer.
  always_comb begin
    state_n     = state_r;
    ball_x_n    = ball_x_r;
    ball_y_n    = ball_y_r;
    vx_n        = vx_r;
    vy_n        = vy_r;
    speed_n     = speed_r;
    hit_cnt_n   = hit_cnt_r;
    serve_cnt_n = serve_cnt_r;
    score_l_n   = score_l_r;
    score_r_n   = score_r_r;
    winner_n    = winner_r;
    serve_dir_n = serve_dir_r;
    p1_hit_n    = 1'b0;
    p2_hit_n    = 1'b0;
    point_l_n   = 1'b0;
    point_r_n   = 1'b0;

    case (state_r)
      IDLE: begin
        ball_x_n = X_CENTER_C;
        ball_y_n = Y_CENTER_C;
        vx_n     = 11'sd0;
        vy_n     = 11'sd0;
        if (start) begin
          state_n     = SERVE;
          serve_cnt_n = '0;
        end else begin
          state_n = IDLE;
        end
      end

      SERVE: begin
        ball_x_n = X_CENTER_C;
        ball_y_n = Y_CENTER_C;
        vx_n     = 11'sd0;
        vy_n     = 11'sd0;
        if (serve_cnt_r == SERVE_LAST) begin
          state_n     = PLAY;
          vx_n        = serve_dir_r ? STEP_INIT_V : -STEP_INIT_V;
          speed_n     = STEP_INIT_V;
          hit_cnt_n   = '0;
          serve_cnt_n = '0;
        end else begin
          serve_cnt_n = serve_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
        end
      end

      PLAY: begin
        if (hit1_s || hit2_s) begin
          // Paddle response: fixed position this frame, new velocity.
          vx_n     = hit1_s ? speed_r : -speed_r;
          vy_n     = hit1_s ? defl1_s : defl2_s;
          p1_hit_n = hit1_s;
          p2_hit_n = hit2_s;
          if (hit_cnt_r == HIT_LAST) begin
            hit_cnt_n = '0;
            speed_n   = speed_up_s;
          end else begin
            hit_cnt_n = hit_cnt_up_s;
          end
        end else if (goal_l_s || goal_r_s) begin
          ball_x_n    = X_CENTER_C;
          ball_y_n    = Y_CENTER_C;
          vx_n        = 11'sd0;
          vy_n        = 11'sd0;
          serve_cnt_n = '0;
          if (goal_l_s) begin
            score_r_n   = score_r_inc_s;
            point_r_n   = 1'b1;
            serve_dir_n = 1'b0;
            if (score_r_inc_s == SCORE_WIN) begin
              state_n  = OVER;
              winner_n = WIN_RIGHT;
            end else begin
              state_n = SERVE;
            end
          end else begin
            score_l_n   = score_l_inc_s;
            point_l_n   = 1'b1;
            serve_dir_n = 1'b1;
            if (score_l_inc_s == SCORE_WIN) begin
              state_n  = OVER;
              winner_n = WIN_LEFT;
            end else begin
              state_n = SERVE;
            end
          end
        end else begin
          // Move with the velocity held at the start of the frame.
          ball_x_n = sum_x_s[9:0];
          ball_y_n = sum_y_s[9:0];
          if (wall_s) begin
            vy_n = -vy_r;
          end else begin
            vy_n = vy_r;
          end
        end
      end

      OVER: begin
        ball_x_n = X_CENTER_C;
        ball_y_n = Y_CENTER_C;
        vx_n     = 11'sd0;
        vy_n     = 11'sd0;
        if (start) begin
          state_n     = SERVE;
          serve_cnt_n = '0;
          score_l_n   = '0;
          score_r_n   = '0;
          winner_n    = WIN_NONE;
        end else begin
          state_n = OVER;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      ball_x_r    <= X_CENTER_C;
      ball_y_r    <= Y_CENTER_C;
      vx_r        <= 11'sd0;
      vy_r        <= 11'sd0;
      speed_r     <= STEP_INIT_V;
      hit_cnt_r   <= '0;
      serve_cnt_r <= '0;
      score_l_r   <= '0;
      score_r_r   <= '0;
      winner_r    <= WIN_NONE;
      serve_dir_r <= 1'b1;
      p1_hit_r    <= 1'b0;
      p2_hit_r    <= 1'b0;
      point_l_r   <= 1'b0;
      point_r_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      ball_x_r    <= ball_x_n;
      ball_y_r    <= ball_y_n;
      vx_r        <= vx_n;
      vy_r        <= vy_n;
      speed_r     <= speed_n;
      hit_cnt_r   <= hit_cnt_n;
      serve_cnt_r <= serve_cnt_n;
      score_l_r   <= score_l_n;
      score_r_r   <= score_r_n;
      winner_r    <= winner_n;
      serve_dir_r <= serve_dir_n;
      p1_hit_r    <= p1_hit_n;
      p2_hit_r    <= p2_hit_n;
      point_l_r   <= point_l_n;
      point_r_r   <= point_r_n;
    end
  end

  assign ball_x      = ball_x_r;
  assign ball_y      = ball_y_r;
  assign ball_s      = BALL_C;
  assign score_l     = score_l_r;
  assign score_r     = score_r_r;
  assign state       = state_r;
  assign winner      = winner_r;
  assign paddle1_hit = p1_hit_r;
  assign paddle2_hit = p2_hit_r;
  assign point_l     = point_l_r;
  assign point_r     = point_r_r;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine with hand-computed expectations.
module tb_pong_ball_engine;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       start;
  logic [9:0] paddle1_x, paddle1_y, paddle1_l, paddle1_w;
  logic [9:0] paddle2_x, paddle2_y, paddle2_l, paddle2_w;
  logic [9:0] ball_x, ball_y, ball_s;
  logic [3:0] score_l, score_r;
  logic [1:0] state, winner;
  logic       paddle1_hit, paddle2_hit, point_l, point_r;

  int n_vec = 0;
  int n_err = 0;

  pong_ball_engine dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .start      (start),
    .paddle1_x  (paddle1_x),
    .paddle1_y  (paddle1_y),
    .paddle1_l  (paddle1_l),
    .paddle1_w  (paddle1_w),
    .paddle2_x  (paddle2_x),
    .paddle2_y  (paddle2_y),
    .paddle2_l  (paddle2_l),
    .paddle2_w  (paddle2_w),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_s     (ball_s),
    .score_l    (score_l),
    .score_r    (score_r),
    .state      (state),
    .winner     (winner),
    .paddle1_hit(paddle1_hit),
    .paddle2_hit(paddle2_hit),
    .point_l    (point_l),
    .point_r    (point_r)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int b;
    int hits;
    int exp_spd;
    logic [9:0] xh;
    logic [9:0] prev_x;
    logic [31:0] dx;

    Reset = 1'b1;
    start = 1'b0;
    paddle1_x = 10'd40;  paddle1_y = 10'd1000; paddle1_l = 10'd2; paddle1_w = 10'd2;
    paddle2_x = 10'd580; paddle2_y = 10'd1000; paddle2_l = 10'd2; paddle2_w = 10'd2;
    #12;
    chk("rst_state", state, 0);
    chk("rst_bx", ball_x, 320);
    chk("rst_by", ball_y, 240);
    chk("rst_bs", ball_s, 5);
    chk("rst_scl", score_l, 0);
    chk("rst_scr", score_r, 0);
    chk("rst_win", winner, 0);
    chk("rst_pulses", {paddle1_hit, paddle2_hit, point_l, point_r}, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    tick(); tick();
    chk("idle_hold", state, 0);

    // Serve: exactly 60 frames, then PLAY at +4
    start = 1'b1; tick(); start = 1'b0;
    chk("serve_enter", state, 1);
    for (int i = 0; i < 59; i++) tick();
    chk("serve_last", state, 1);
    tick();
    chk("play_enter", state, 2);
    chk("play_bx0", ball_x, 320);
    tick();
    chk("play_bx1", ball_x, 324);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ign_play", state, 2);
    chk("play_bx2", ball_x, 328);

    // Paddle2 hit: (572-216)... ball_y 240 vs paddle 216 -> +24>>>3 = +3
    paddle2_y = 10'd216; paddle2_l = 10'd30; paddle2_w = 10'd4;
    b = 0;
    while (!paddle2_hit && b < 300) begin tick(); b++; end
    chk("p2_hit", paddle2_hit, 1);
    chk("p2_hit_bx", ball_x, 572);
    chk("p2_hit_by", ball_y, 240);
    hits = 1;

    // Bottom wall with vy=+3, vx=-4
    for (int i = 0; i < 72; i++) tick();
    chk("p2_pulse_once", paddle2_hit, 0);
    chk("bw_pre_bx", ball_x, 284);
    chk("bw_pre_by", ball_y, 456);
    tick();
    chk("bw_flip_by", ball_y, 459);
    chk("bw_flip_bx", ball_x, 280);
    tick();
    chk("bw_noreflip_by", ball_y, 456);
    tick();
    chk("bw_cont_by", ball_y, 453);

    // Speed ramp rally with paddles tracking the ball (zero deflection)
    paddle1_l = 10'd30; paddle1_w = 10'd4;
    b = 0;
    while (hits < 36 && b < 20000 && state == 2'd2) begin
      paddle1_y = ball_y; paddle2_y = ball_y;
      tick(); b++;
      if (paddle1_hit || paddle2_hit) begin
        hits++;
        xh = ball_x;
        paddle1_y = ball_y; paddle2_y = ball_y;
        tick(); b++;
        dx = (ball_x > xh) ? 32'(ball_x - xh) : 32'(xh - ball_x);
        exp_spd = 4 + (hits - 1) / 4;
        if (exp_spd > 12) exp_spd = 12;
        chk($sformatf("ramp_speed_hit%0d", hits), dx, exp_spd);
      end
    end
    chk("ramp_hits", hits, 36);
    chk("ramp_state", state, 2);

    // Right goal with paddle2 parked
    paddle1_y = 10'd1000; paddle2_y = 10'd1000;
    b = 0;
    while (!point_l && b < 300) begin tick(); b++; end
    chk("rg_point_l", point_l, 1);
    chk("rg_point_r", point_r, 0);
    chk("rg_score_l", score_l, 1);
    chk("rg_score_r", score_r, 0);
    chk("rg_state", state, 1);
    chk("rg_bx", ball_x, 320);
    chk("rg_by", ball_y, 240);
    tick();
    chk("rg_pulse_once", point_l, 0);
    for (int i = 0; i < 58; i++) tick();
    chk("rg_serve_last", state, 1);
    tick();
    chk("rg_play", state, 2);
    tick();
    chk("rg_serve_vx", ball_x, 324);

    // Goals 2..7 at serve speed, all detected at ball_x = 592
    for (int g = 2; g <= 7; g++) begin
      b = 0;
      prev_x = ball_x;
      while (!point_l && b < 400) begin prev_x = ball_x; tick(); b++; end
      chk($sformatf("goal%0d_x", g), prev_x, 592);
      chk($sformatf("goal%0d_score", g), score_l, g);
      if (g < 7) begin
        b = 0;
        while (state != 2'd2 && b < 100) begin tick(); b++; end
        chk($sformatf("goal%0d_replay", g), state, 2);
      end
    end
    chk("over_state", state, 3);
    chk("over_winner", winner, 1);
    chk("over_bx", ball_x, 320);
    tick();
    chk("over_hold", state, 3);

    // Restart from OVER keeps serve direction +x
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_scl", score_l, 0);
    chk("restart_win", winner, 0);
    for (int i = 0; i < 60; i++) tick();
    chk("restart_play", state, 2);
    tick();
    chk("restart_bx", ball_x, 324);

    // Clamped negative deflection: (240-320)>>>3 = -10 -> -7
    paddle2_y = 10'd320; paddle2_l = 10'd100;
    b = 0;
    while (!paddle2_hit && b < 300) begin tick(); b++; end
    chk("clamp_hit", paddle2_hit, 1);
    chk("clamp_hit_bx", ball_x, 572);
    tick();
    chk("clamp_bx", ball_x, 568);
    chk("clamp_by", ball_y, 233);
    for (int i = 0; i < 30; i++) tick();
    chk("tw_pre_bx", ball_x, 448);
    chk("tw_pre_by", ball_y, 23);
    tick();
    chk("tw_flip_by", ball_y, 16);
    tick();
    chk("tw_after_by", ball_y, 23);
    chk("tw_after_bx", ball_x, 440);

    // Left goal
    b = 0;
    while (!point_r && b < 300) begin tick(); b++; end
    chk("lg_point_r", point_r, 1);
    chk("lg_score_r", score_r, 1);
    chk("lg_score_l", score_l, 0);
    chk("lg_state", state, 1);
    chk("lg_bx", ball_x, 320);
    for (int i = 0; i < 60; i++) tick();
    chk("lg_play", state, 2);
    tick();
    chk("lg_serve_vx", ball_x, 316);

    // Asynchronous reset mid-PLAY
    tick();
    #2 Reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_bx", ball_x, 320);
    chk("arst_by", ball_y, 240);
    chk("arst_scr", score_r, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();
    chk("arst_idle", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
